// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and defaults for the MIPS core and its boot sequencer
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } boot_state_t;

    localparam int          WORD_BYTES       = 4;
    localparam int          IMEM_DEPTH_WORDS = 64;
    localparam logic [31:0] IMEM_BASE_ADDR   = 32'h0;

endpackage

// File: rtl/boot_write_port.sv
// rtl/boot_write_port.sv - registered instruction-memory write stage with address generator
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   wr_req                   a word was accepted this cycle
//   wr_index                 slot index of the accepted word (word count before increment)
//   wr_data                  accepted instruction word
//   instrdatain, addwrite    registered write data / byte address
//   instwen                  registered write enable, one cycle after wr_req
module boot_write_port
    import mips_pkg::*;
#(
    parameter int          CW        = 7,
    parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
    parameter int          ADDR_STEP = WORD_BYTES
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_req,
    input  logic [CW-1:0] wr_index,
    input  logic [31:0]   wr_data,
    output logic [31:0]   instrdatain,
    output logic [31:0]   addwrite,
    output logic          instwen
);

    // Address wraps modulo 2^32 by construction of the 32-bit arithmetic.
    logic [31:0] slot_addr;
    assign slot_addr = BASE_ADDR + 32'(wr_index) * 32'(ADDR_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instwen     <= 1'b0;
            instrdatain <= 32'h0;
            addwrite    <= BASE_ADDR;
        end else begin
            instwen <= wr_req;
            // Data/address hold their last value between writes.
            if (wr_req) begin
                instrdatain <= wr_data;
                addwrite    <= slot_addr;
            end
        end
    end

endmodule

// File: rtl/imem_boot_sequencer.sv
// rtl/imem_boot_sequencer.sv - loads a program stream into instruction memory and releases the core
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   start                           pulse to begin a load (from IDLE or RUN)
//   s_valid, s_data, s_last,
//   s_ready                         program word stream
//   instrdatain, addwrite, instwen  instruction memory write port
//   core_reset                      active-high reset held on the datapath until RUN
//   busy, done                      load/settle in progress, core running
//   word_count, overflow            words written in this load, program truncated
module imem_boot_sequencer
    import mips_pkg::*;
#(
    parameter int          DEPTH_WORDS   = IMEM_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR     = IMEM_BASE_ADDR,
    parameter int          ADDR_STEP     = WORD_BYTES,
    parameter int          SETTLE_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         s_valid,
    input  logic [31:0]                  s_data,
    input  logic                         s_last,
    output logic                         s_ready,
    output logic [31:0]                  instrdatain,
    output logic [31:0]                  addwrite,
    output logic                         instwen,
    output logic                         core_reset,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH_WORDS):0] word_count,
    output logic                         overflow
);

    localparam int CW = $clog2(DEPTH_WORDS) + 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    boot_state_t   state;
    logic [SW-1:0] settle_cnt;
    logic          accept;
    logic          last_slot;

    // Status outputs are pure decodes of state so an async reset or a
    // reload edge changes them without an extra register stage.
    assign s_ready    = (state == LOAD);
    assign busy       = (state == LOAD) || (state == SETTLE);
    assign done       = (state == RUN);
    assign core_reset = (state != RUN);

    assign accept    = s_valid && s_ready;
    assign last_slot = (word_count == CW'(DEPTH_WORDS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            word_count <= '0;
            overflow   <= 1'b0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (start) begin
                        state      <= LOAD;
                        word_count <= '0;
                        overflow   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        word_count <= word_count + CW'(1);
                        if (s_last) begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                        end else if (last_slot) begin
                            // Memory is full but the program is not: truncate.
                            overflow   <= 1'b1;
                            state      <= SETTLE;
                            settle_cnt <= '0;
                        end
                    end
                end
                SETTLE: begin
                    // The first SETTLE cycle carries the final write pulse.
                    if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        state <= RUN;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    boot_write_port #(
        .CW        (CW),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_STEP (ADDR_STEP)
    ) u_write_port (
        .clk         (clk),
        .rst_n       (reset),
        .wr_req      (accept),
        .wr_index    (word_count),
        .wr_data     (s_data),
        .instrdatain (instrdatain),
        .addwrite    (addwrite),
        .instwen     (instwen)
    );

endmodule

// File: doc/imem_boot_sequencer.md
Name: imem_boot_sequencer

Overview:
- Boot/reload sequencer for the single-cycle MIPS core.
- Accepts a program as a valid/ready word stream and writes it into instruction memory through its write port (instrdatain, addwrite, instwen).
- Holds the core (datapath PC/regfile) in reset during load, then releases it after a programmable settle delay.
- Sits between the testbench/host interface and the top-level core wrapper.

Parameters:
- DEPTH_WORDS, 64, instruction memory capacity in 32-bit words.
- BASE_ADDR, 32'h0, byte address of the first instruction.
- ADDR_STEP, 4, byte increment per word (matches PC+4).
- SETTLE_CYCLES, 2, cycles core_reset stays high after the last write; must be ≥1.

Ports:
- clk, in, 1, system clock, rising edge.
- reset, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle pulse to begin a program load.
- s_valid, in, 1, stream word valid.
- s_data, in, 32, instruction word.
- s_last, in, 1, marks the final word of the program.
- s_ready, out, 1, sequencer accepts a word this cycle.
- instrdatain, out, 32, instruction memory write data.
- addwrite, out, 32, instruction memory write byte address.
- instwen, out, 1, instruction memory write enable.
- core_reset, out, 1, active-high reset to the datapath.
- busy, out, 1, load or settle in progress.
- done, out, 1, program loaded and core running.
- word_count, out, $clog2(DEPTH_WORDS)+1, words written in the current or last load.
- overflow, out, 1, program was truncated at DEPTH_WORDS.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, core_reset=1, s_ready=0, instwen=0, instrdatain=0, addwrite=BASE_ADDR.
  - busy=0, done=0, word_count=0, overflow=0, settle counter=0.
- States: IDLE, LOAD, SETTLE, RUN.
- IDLE:
  - core_reset=1, s_ready=0; stream input ignored.
  - start=1 → LOAD; clears word_count and overflow.
- LOAD:
  - s_ready=1 combinationally from state; busy=1; core_reset=1.
  - Handshake: a word transfers when s_valid && s_ready.
  - Writes are registered with 1-cycle latency. The cycle after acceptance: instwen=1, instrdatain=s_data, addwrite=BASE_ADDR + word_count_old*ADDR_STEP (32-bit, wraps mod 2^32). word_count increments on acceptance.
  - instwen=0 in every cycle that does not follow an acceptance; back-to-back words give consecutive write cycles.
  - Accepted word with s_last=1 → SETTLE.
  - Accepted word filling the last slot (word_count_old==DEPTH_WORDS-1) with s_last=0 → overflow=1 (sticky until next start), → SETTLE. Later stream words are not accepted.
  - start is ignored while in LOAD.
- SETTLE:
  - s_ready=0, core_reset=1, busy=1.
  - The final write's instwen pulse occurs in the first SETTLE cycle.
  - Counter runs SETTLE_CYCLES cycles, then → RUN.
- RUN:
  - core_reset=0, done=1, busy=0, s_ready=0.
  - start=1 → LOAD: core_reset=1 and done=0 from the same clock edge; word_count and overflow cleared.
- Reset asserted mid-load: immediate return to IDLE values. Any partial program in memory is left in place but not run (core_reset=1).
- No write ever occurs outside LOAD/first-SETTLE-cycle; instwen never asserts with core_reset=0.

Decomposition:
- Shared package (mips_pkg):
  - boot_state_t enum {IDLE, LOAD, SETTLE, RUN}.
  - Constant WORD_BYTES=4.
  - Defaults for DEPTH_WORDS and BASE_ADDR, shared with instructionmem.
- Sub-module: boot_write_port, the registered instrdatain/addwrite/instwen stage with an address generator. The FSM stays in the parent.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, no start → core_reset=1, done=0, instwen=0, s_ready=0 for 20 cycles.
- Normal load: start, then 4 words 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000 back-to-back with s_last on word 4 → four instwen pulses at addwrite 0x0, 0x4, 0x8, 0xC; word_count=4; core_reset falls 2 cycles after the last write cycle. The core then executes and dmem[0]=8.
- Backpressure gaps: s_valid toggles 1,0,0,1,0,1 (3 words, last on third) → exactly 3 writes at consecutive addresses, no write in gap cycles, data matches.
- Overflow: DEPTH_WORDS=4, stream 6 words with no s_last → 4 writes (0x0–0xC), overflow=1, s_ready=0 after the 4th word, core released normally.
- Reload from RUN: start while running → core_reset=1 the next cycle, done=0. New 2-word program written at 0x0 and 0x4, then run.
- Async reset mid-load: assert reset after 2 of 5 words (between clock edges) → outputs immediately at reset values. A subsequent start+load of 3 words completes correctly with word_count=3.
